// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop
// shifter. The status byte and the tx pin are both driven straight from flops.
module uart_tx_port #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 clear_overflow,
  output logic                 tx,
  output logic [7:0]           status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0]        baud, baud_n;
  logic [2:0]           bitc, bitc_n;
  logic                 ovf, ovf_n;
  logic                 push, pop, full, empty, bit_end, tx_n;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push    = write_en && !full;
  assign bit_end = (baud == BAUD_LAST);
  assign cnt_n   = cnt + CW'(push) - CW'(pop);
  // A dropped write beats a simultaneous clear.
  assign ovf_n   = (write_en && full) ? 1'b1 : (clear_overflow ? 1'b0 : ovf);

  always_comb begin
    state_n = state;
    shift_n = shift;
    baud_n  = baud;
    bitc_n  = bitc;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          baud_n  = '0;
          bitc_n  = '0;
          state_n = START;
        end
      end
      START: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bitc == BIT_LAST) state_n = STOP;
          else                  bitc_n  = bitc + 1'b1;
        end
      end
      STOP: begin
        baud_n = bit_end ? '0 : baud + 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rptr];
            bitc_n  = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      shift  <= '0;
      baud   <= '0;
      bitc   <= '0;
      ovf    <= 1'b0;
      tx     <= 1'b1;
      status <= 8'h01;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      baud   <= baud_n;
      bitc   <= bitc_n;
      cnt    <= cnt_n;
      ovf    <= ovf_n;
      tx     <= tx_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      status <= {4'b0, ovf_n, state_n != IDLE, cnt_n == FULL_CNT, cnt_n == '0};
    end
  end
endmodule
